// File: rtl/rand_arb_pkg.sv
// Shared types and constants for the round-robin random-value arbiter.
package rand_arb_pkg;

  localparam int RAND_W_DEF = 16;
  localparam int MAX_REQ    = 8;
  localparam int IDX_W      = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    DELIVER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rand_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_pick
  import rand_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Smallest wrapped distance from the pointer wins.
  always_comb begin
    int w_best;
    int w_dist;
    logic w_hit;
    w_best  = NUM_REQ;
    w_dist  = 0;
    w_hit   = 1'b0;
    o_idx   = {IDX_W{1'b0}};
    o_valid = |i_req;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NUM_REQ - int'(i_ptr));
      w_hit  = i_req[i] && (w_dist < w_best);
      w_best = w_hit ? w_dist : w_best;
      o_idx  = w_hit ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one LFSR; one advance per grant, fresh value to the winner.
// Optional build macro RAND_ARB_FREERUN_EN: LFSR also free-runs while IDLE.
module rand_arbiter
  import rand_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RAND_W  = RAND_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pause_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [RAND_W-1:0]  rand_o,
  output logic               busy_o,
  output logic               lfsr_next_o,
  input  logic [RAND_W-1:0]  lfsr_rand_i
);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_winner;
  logic [IDX_W-1:0] w_ptr_adv;
  logic [IDX_W-1:0] w_pick_ptr;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_arb_go;
  logic             w_idle_next;

`ifdef RAND_ARB_FREERUN_EN
  assign w_idle_next = rst_ni;
`else
  assign w_idle_next = 1'b0;
`endif

  assign w_ptr_adv  = (r_winner == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : (r_winner + IDX_W'(1));
  // Back-to-back re-arbitration in DELIVER already uses the pointer being written this cycle.
  assign w_pick_ptr = (r_state == DELIVER) ? w_ptr_adv : r_ptr;
  assign w_arb_go   = w_pick_valid & ~pause_i;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (req_i),
    .i_ptr   (w_pick_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_arb_go ? ADVANCE : IDLE;
      ADVANCE: w_state_next = DELIVER;
      DELIVER: w_state_next = w_arb_go ? ADVANCE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr    <= {IDX_W{1'b0}};
      r_winner <= {IDX_W{1'b0}};
    end else begin
      if (r_state == DELIVER) begin
        r_ptr <= w_ptr_adv;
      end
      if (((r_state == IDLE) || (r_state == DELIVER)) && w_arb_go) begin
        r_winner <= w_pick_idx;
      end
    end
  end

  always_comb begin
    gnt_o       = {NUM_REQ{1'b0}};
    lfsr_next_o = 1'b0;
    busy_o      = (r_state != IDLE);
    case (r_state)
      IDLE:    lfsr_next_o = w_idle_next;
      ADVANCE: lfsr_next_o = 1'b1;
      DELIVER: begin
        // A winner that dropped its request forfeits the value.
        for (int i = 0; i < NUM_REQ; i++) begin
          gnt_o[i] = (r_winner == IDX_W'(i)) & req_i[i];
        end
      end
      default: lfsr_next_o = 1'b0;
    endcase
    rand_o = (|gnt_o) ? lfsr_rand_i : {RAND_W{1'b0}};
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter: cycle vector tables, grant scoreboard, reset corner case.
module tb_rand_arbiter;

  localparam int NR = 4;
  localparam int RW = 16;
`ifdef RAND_ARB_FREERUN_EN
  localparam logic IN = 1'b1;
`else
  localparam logic IN = 1'b0;
`endif

  typedef struct packed {
    logic [NR-1:0] req;
    logic          pause;
    logic [NR-1:0] gnt;
    logic          nxt;
    logic          busy;
  } vec_t;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [RW-1:0] rnd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          pause_i;
  logic [NR-1:0] req_i;
  logic [NR-1:0] gnt_o;
  logic [RW-1:0] rand_o;
  logic          busy_o;
  logic          lfsr_next_o;
  logic [RW-1:0] lfsr_rand_i;
  logic [RW-1:0] env_lfsr = 16'hACE1;
  logic [RW-1:0] m_lfsr;
  logic [RW-1:0] prev_rand;
  logic          have_prev;
  exp_t          sb_q[$];
  int            chk_cnt = 0;
  int            err_cnt = 0;
  vec_t          vec1[35];
  vec_t          vec2[18];

  always #5 clk = ~clk;

  rand_arbiter #(.NUM_REQ(NR), .RAND_W(RW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .pause_i     (pause_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rand_o      (rand_o),
    .busy_o      (busy_o),
    .lfsr_next_o (lfsr_next_o),
    .lfsr_rand_i (lfsr_rand_i)
  );

  function automatic logic [RW-1:0] lfsr_step(input logic [RW-1:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic vec_t mk(input logic [NR-1:0] r, input logic p, input logic [NR-1:0] g,
                              input logic n, input logic b);
    return '{req: r, pause: p, gnt: g, nxt: n, busy: b};
  endfunction

  // Stand-in LFSR instance, advanced only by the DUT strobe.
  assign lfsr_rand_i = env_lfsr;
  always @(posedge clk) begin
    if (lfsr_next_o) env_lfsr <= lfsr_step(env_lfsr);
  end

  // Grant monitor: pops the scoreboard on every grant, flags missing or spurious ones.
  always @(negedge clk) begin
    exp_t e;
    if (gnt_o != 4'd0) begin
      chk_cnt++;
      if (sb_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_grant got gnt=%b rand=%h want no grant", gnt_o, rand_o);
      end else begin
        e = sb_q.pop_front();
        if (gnt_o !== e.gnt || rand_o !== e.rnd) begin
          err_cnt++;
          $display("FAIL grant got gnt=%b rand=%h want gnt=%b rand=%h", gnt_o, rand_o, e.gnt, e.rnd);
        end
      end
      if (have_prev) begin
        chk_cnt++;
        if (rand_o == prev_rand) begin
          err_cnt++;
          $display("FAIL rand_repeat got %h twice want distinct", rand_o);
        end
      end
      prev_rand = rand_o;
      have_prev = 1'b1;
    end else begin
      chk_cnt++;
      if (rand_o !== 16'd0) begin
        err_cnt++;
        $display("FAIL rand_idle got %h want 0000", rand_o);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk_cnt++;
        err_cnt++;
        $display("FAIL missing_grant got gnt=%b want gnt=%b", gnt_o, e.gnt);
      end
    end
  end

  task automatic apply_row(input vec_t v, input int tbl, input int idx);
    req_i   = v.req;
    pause_i = v.pause;
    if (v.gnt != 4'd0) sb_q.push_back('{gnt: v.gnt, rnd: m_lfsr});
    @(negedge clk);
    chk_cnt++;
    if (lfsr_next_o !== v.nxt || busy_o !== v.busy) begin
      err_cnt++;
      $display("FAIL vec%0d[%0d] next/busy got %b/%b want %b/%b", tbl, idx,
               lfsr_next_o, busy_o, v.nxt, v.busy);
    end
    if (v.nxt) m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = 4'b0000;
    pause_i   = 1'b0;
    m_lfsr    = 16'hACE1;
    prev_rand = 16'h0000;
    have_prev = 1'b0;

    // single request, then re-arbitration of a held request that drops
    vec1[0]  = mk(4'b0001, 1'b0, 4'b0000, IN,   1'b0);
    vec1[1]  = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[2]  = mk(4'b0001, 1'b0, 4'b0001, 1'b0, 1'b1);
    vec1[3]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[4]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    vec1[5]  = mk(4'b0000, 1'b0, 4'b0000, IN,   1'b0);
    // all four requesting: rotation 1,2,3,0,1
    vec1[6]  = mk(4'b1111, 1'b0, 4'b0000, IN,   1'b0);
    vec1[7]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[8]  = mk(4'b1111, 1'b0, 4'b0010, 1'b0, 1'b1);
    vec1[9]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[10] = mk(4'b1111, 1'b0, 4'b0100, 1'b0, 1'b1);
    vec1[11] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[12] = mk(4'b1111, 1'b0, 4'b1000, 1'b0, 1'b1);
    vec1[13] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[14] = mk(4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1);
    vec1[15] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[16] = mk(4'b1111, 1'b0, 4'b0010, 1'b0, 1'b1);
    vec1[17] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[18] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    // request dropped during ADVANCE, then wrap to bit 0
    vec1[19] = mk(4'b0010, 1'b0, 4'b0000, IN,   1'b0);
    vec1[20] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[21] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    vec1[22] = mk(4'b0011, 1'b0, 4'b0000, IN,   1'b0);
    vec1[23] = mk(4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[24] = mk(4'b0011, 1'b0, 4'b0001, 1'b0, 1'b1);
    vec1[25] = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[26] = mk(4'b0010, 1'b0, 4'b0010, 1'b0, 1'b1);
    vec1[27] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec1[28] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    // pause blocks a new arbitration but not one in flight
    vec1[29] = mk(4'b0100, 1'b1, 4'b0000, IN,   1'b0);
    vec1[30] = mk(4'b0100, 1'b1, 4'b0000, IN,   1'b0);
    vec1[31] = mk(4'b0100, 1'b0, 4'b0000, IN,   1'b0);
    vec1[32] = mk(4'b0100, 1'b1, 4'b0000, 1'b1, 1'b1);
    vec1[33] = mk(4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1);
    vec1[34] = mk(4'b0000, 1'b0, 4'b0000, IN,   1'b0);

    // after the mid-DELIVER reset: pointer back at 0, then 5 idle cycles
    vec2[0]  = mk(4'b1010, 1'b0, 4'b0000, IN,   1'b0);
    vec2[1]  = mk(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec2[2]  = mk(4'b1010, 1'b0, 4'b0010, 1'b0, 1'b1);
    vec2[3]  = mk(4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec2[4]  = mk(4'b1000, 1'b0, 4'b1000, 1'b0, 1'b1);
    vec2[5]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec2[6]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    for (int k = 7; k < 12; k++) vec2[k] = mk(4'b0000, 1'b0, 4'b0000, IN, 1'b0);
    vec2[12] = mk(4'b0100, 1'b0, 4'b0000, IN,   1'b0);
    vec2[13] = mk(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec2[14] = mk(4'b0100, 1'b0, 4'b0100, 1'b0, 1'b1);
    vec2[15] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
    vec2[16] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    vec2[17] = mk(4'b0000, 1'b0, 4'b0000, IN,   1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (gnt_o !== 4'd0 || rand_o !== 16'd0 || busy_o !== 1'b0 || lfsr_next_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state got gnt=%b rand=%h busy=%b next=%b want all 0",
               gnt_o, rand_o, busy_o, lfsr_next_o);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 35; i++) apply_row(vec1[i], 1, i);

    // in-flight grant killed by reset in the DELIVER cycle (pointer is 3 here)
    req_i   = 4'b1010;
    pause_i = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_seq_idle busy got %b want 0", busy_o);
    end
    if (IN) m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_cnt++;
    if (lfsr_next_o !== 1'b1 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_seq_adv next/busy got %b/%b want 1/1", lfsr_next_o, busy_o);
    end
    m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
    chk_cnt++;
    if (gnt_o !== 4'b1000 || rand_o !== m_lfsr) begin
      err_cnt++;
      $display("FAIL rst_seq_deliver got gnt=%b rand=%h want gnt=1000 rand=%h", gnt_o, rand_o, m_lfsr);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    chk_cnt++;
    if (gnt_o !== 4'd0 || rand_o !== 16'd0 || busy_o !== 1'b0 || lfsr_next_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_async got gnt=%b rand=%h busy=%b next=%b want all 0",
               gnt_o, rand_o, busy_o, lfsr_next_o);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) apply_row(vec2[i], 2, i);

    chk_cnt++;
    if (sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
